// File: rtl/rsc_symbol_encoder_pkg.sv
// Shared turbo package: trellis FSM state type and the +1.0/-1.0 float
// encodings used for antipodal symbol mapping by the encoder and the
// branch-metric blocks.
package rsc_symbol_encoder_pkg;

    typedef enum logic [1:0] {
        ST_DATA  = 2'd0,
        ST_TAIL1 = 2'd1,
        ST_TAIL2 = 2'd2
    } enc_state_e;

    localparam logic [15:0] HALF_POS_ONE   = 16'h3C00;
    localparam logic [15:0] HALF_NEG_ONE   = 16'hBC00;
    localparam logic [31:0] SINGLE_POS_ONE = 32'h3F800000;
    localparam logic [31:0] SINGLE_NEG_ONE = 32'hBF800000;

    // Bit 0 maps to +1.0 and bit 1 to -1.0; half results are zero-extended.
    function automatic logic [31:0] bit_to_float(input logic b, input logic is_single);
        logic [31:0] f;
        if (is_single) begin
            f = b ? SINGLE_NEG_ONE : SINGLE_POS_ONE;
        end else begin
            f = {16'h0000, (b ? HALF_NEG_ONE : HALF_POS_ONE)};
        end
        return f;
    endfunction

endpackage

// File: rtl/rsc_symbol_encoder_trellis_step.sv
// One step of the 4-state recursive systematic convolutional code.
// Feedback a = u^s1^s2, parity = a^s2, next state (a, s1).
module rsc_trellis_step (
    input  logic u_i,
    input  logic s1_i,
    input  logic s2_i,
    output logic sys_o,
    output logic par_o,
    output logic s1_next_o,
    output logic s2_next_o
);

    logic feedback;

    assign feedback  = u_i ^ s1_i ^ s2_i;
    assign sys_o     = u_i;
    assign par_o     = feedback ^ s2_i;
    assign s1_next_o = feedback;
    assign s2_next_o = s1_i;

endmodule

// File: rtl/rsc_symbol_encoder.sv
// RSC symbol encoder: accepts information bits with valid/ready, emits one
// (systematic, parity) float symbol pair per trellis step, then two
// termination steps that drive the trellis back to state (0,0).
// BITS must not exceed 32; only BITS_PER_SYMBOL = 2 carries data.
module rsc_symbol_encoder
    import rsc_symbol_encoder_pkg::*;
#(
    parameter int    BITS            = 16,
    parameter string PRECISION       = "HALF",
    parameter int    BITS_PER_SYMBOL = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_bit,
    input  logic            in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] symbol [BITS_PER_SYMBOL],
    output logic            out_tail,
    output logic            out_last
);

    localparam logic IS_SINGLE = (PRECISION == "SINGLE");

    enc_state_e state_q, state_d;
    logic       s1_q, s1_d;
    logic       s2_q, s2_d;
    logic       valid_q, valid_d;
    logic       sys_q, sys_d;
    logic       par_q, par_d;
    logic       tail_q, tail_d;
    logic       last_q, last_d;

    logic       can_advance;
    logic       step_en;
    logic       step_u;
    logic       step_sys;
    logic       step_par;
    logic       step_s1;
    logic       step_s2;
    logic [31:0] float_word;

    // The output register is free when empty or being drained this cycle.
    assign can_advance = !valid_q || out_ready;
    assign in_ready    = rst_n && (state_q == ST_DATA) && can_advance;

    // Termination steps choose u so the feedback bit is zero.
    assign step_u = (state_q == ST_DATA) ? in_bit : (s1_q ^ s2_q);

    rsc_trellis_step u_step (
        .u_i       (step_u),
        .s1_i      (s1_q),
        .s2_i      (s2_q),
        .sys_o     (step_sys),
        .par_o     (step_par),
        .s1_next_o (step_s1),
        .s2_next_o (step_s2)
    );

    // Next-state logic: decide whether a trellis step happens and update the FSM.
    always_comb begin
        state_d = state_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        valid_d = valid_q;
        sys_d   = sys_q;
        par_d   = par_q;
        tail_d  = tail_q;
        last_d  = last_q;
        step_en = 1'b0;

        case (state_q)
            ST_DATA: begin
                if (in_valid && in_ready) begin
                    step_en = 1'b1;
                    if (in_last) begin
                        state_d = ST_TAIL1;
                    end
                end
            end
            ST_TAIL1: begin
                if (can_advance) begin
                    step_en = 1'b1;
                    state_d = ST_TAIL2;
                end
            end
            ST_TAIL2: begin
                if (can_advance) begin
                    step_en = 1'b1;
                    state_d = ST_DATA;
                end
            end
            default: begin
                state_d = ST_DATA;
            end
        endcase

        if (step_en) begin
            s1_d    = step_s1;
            s2_d    = step_s2;
            valid_d = 1'b1;
            sys_d   = step_sys;
            par_d   = step_par;
            tail_d  = (state_q != ST_DATA);
            last_d  = (state_q == ST_TAIL2);
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // State and output registers; reset clears the trellis and any pending symbol.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_DATA;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            valid_q <= 1'b0;
            sys_q   <= 1'b0;
            par_q   <= 1'b0;
            tail_q  <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            valid_q <= valid_d;
            sys_q   <= sys_d;
            par_q   <= par_d;
            tail_q  <= tail_d;
            last_q  <= last_d;
        end
    end

    // Map the registered bits onto float words; unused slots carry +1.0.
    always_comb begin
        float_word = '0;
        for (int i = 0; i < BITS_PER_SYMBOL; i++) begin
            float_word = bit_to_float((i == 0) ? sys_q : ((i == 1) ? par_q : 1'b0), IS_SINGLE);
            symbol[i]  = float_word[BITS-1:0];
        end
    end

    assign out_valid = valid_q;
    assign out_tail  = tail_q;
    assign out_last  = last_q;

endmodule
